// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: latches a six-entry code table, then consumes one
// codeword bit per cycle (MSB first) and emits the decoded gray symbol 1..6.
module huffman_decoder #(
  parameter int TOTAL  = 100,  // symbols per frame
  parameter int MAXLEN = 7     // longest legal codeword; table entries are 8 bits wide
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] HC1,
  input  logic [7:0] HC2,
  input  logic [7:0] HC3,
  input  logic [7:0] HC4,
  input  logic [7:0] HC5,
  input  logic [7:0] HC6,
  input  logic [7:0] M1,
  input  logic [7:0] M2,
  input  logic [7:0] M3,
  input  logic [7:0] M4,
  input  logic [7:0] M5,
  input  logic [7:0] M6,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       bit_ready,
  output logic       sym_valid,
  output logic [7:0] sym_data,
  output logic [7:0] sym_cnt,
  output logic       dec_err,
  output logic       dec_done
);

  typedef enum logic [1:0] {S_WAIT_TABLE, S_DECODE, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] hc_q  [6];
  logic [7:0] m_q   [6];
  logic [3:0] len_tab_q [6];   // codeword length of each symbol, from its mask
  logic [6:0] shreg_q, shreg_d;
  logic [3:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sym_valid_q, sym_valid_d;
  logic       dec_err_q, dec_err_d;
  logic [7:0] sym_data_q, sym_data_d;

  logic [7:0] hc_in [6];
  logic [7:0] m_in  [6];
  logic [7:0] cand;
  logic [3:0] clen;
  logic       match_found;
  logic [2:0] match_idx;

  // Number of ones in a mask gives the codeword length.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) n = n + {3'd0, v[k]};
    return n;
  endfunction

  // Gather the table ports into arrays so the lookup can loop over them.
  always_comb begin
    hc_in[0] = HC1; hc_in[1] = HC2; hc_in[2] = HC3;
    hc_in[3] = HC4; hc_in[4] = HC5; hc_in[5] = HC6;
    m_in[0]  = M1;  m_in[1]  = M2;  m_in[2]  = M3;
    m_in[3]  = M4;  m_in[4]  = M5;  m_in[5]  = M6;
  end

  // Candidate codeword including the incoming bit; scan downwards so the
  // lowest-numbered symbol wins when a table is not prefix-free.
  always_comb begin
    cand        = {shreg_q, bit_in};
    clen        = len_q + 4'd1;
    match_found = 1'b0;
    match_idx   = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (len_tab_q[i] == clen && (cand & m_q[i]) == hc_q[i]) begin
        match_found = 1'b1;
        match_idx   = 3'(i + 1);
      end
    end
  end

  // Next-state and datapath update; a table load overrides everything else.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sym_valid_d = 1'b0;
    dec_err_d   = 1'b0;
    sym_data_d  = sym_data_q;
    if (code_valid) begin
      state_d = S_DECODE;
      shreg_d = '0;
      len_d   = '0;
      cnt_d   = '0;
    end else if (state_q == S_DECODE && bit_valid) begin
      if (match_found) begin
        sym_valid_d = 1'b1;
        sym_data_d  = {5'd0, match_idx};
        shreg_d     = '0;
        len_d       = '0;
        cnt_d       = cnt_q + 8'd1;
        if (cnt_q + 8'd1 == 8'(TOTAL)) state_d = S_DONE;
      end else if (clen >= 4'(MAXLEN)) begin
        dec_err_d = 1'b1;
        shreg_d   = '0;
        len_d     = '0;
      end else begin
        shreg_d = cand[6:0];
        len_d   = clen;
      end
    end
  end

  // Code table registers, reloaded on every code_valid pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        hc_q[i]      <= '0;
        m_q[i]       <= '0;
        len_tab_q[i] <= '0;
      end
    end else if (code_valid) begin
      for (int i = 0; i < 6; i++) begin
        hc_q[i]      <= hc_in[i];
        m_q[i]       <= m_in[i];
        len_tab_q[i] <= popcount8(m_in[i]);
      end
    end
  end

  // State, bit accumulator, counter and registered output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_WAIT_TABLE;
      shreg_q     <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      sym_valid_q <= 1'b0;
      dec_err_q   <= 1'b0;
      sym_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sym_valid_q <= sym_valid_d;
      dec_err_q   <= dec_err_d;
      sym_data_q  <= sym_data_d;
    end
  end

  assign bit_ready = (state_q == S_DECODE);
  assign dec_done  = (state_q == S_DONE);
  assign sym_valid = sym_valid_q;
  assign dec_err   = dec_err_q;
  assign sym_data  = sym_data_q;
  assign sym_cnt   = cnt_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: directed scenarios plus randomized tables and
// bitstreams, all compared against a bit-string reference model.
module tb_huffman_decoder;
  localparam int TOTAL  = 100;
  localparam int MAXLEN = 7;

  logic       clk = 1'b0;
  logic       reset, code_valid, bit_valid, bit_in;
  logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6;
  logic       bit_ready, sym_valid, dec_err, dec_done;
  logic [7:0] sym_data, sym_cnt;

  logic [7:0] t_hc [1:6];
  int         t_len [1:6];

  function automatic logic [7:0] lmask(input int l);
    return 8'((1 << l) - 1);
  endfunction

  assign HC1 = t_hc[1]; assign HC2 = t_hc[2]; assign HC3 = t_hc[3];
  assign HC4 = t_hc[4]; assign HC5 = t_hc[5]; assign HC6 = t_hc[6];
  assign M1 = lmask(t_len[1]); assign M2 = lmask(t_len[2]); assign M3 = lmask(t_len[3]);
  assign M4 = lmask(t_len[4]); assign M5 = lmask(t_len[5]); assign M6 = lmask(t_len[6]);

  huffman_decoder #(.TOTAL(TOTAL), .MAXLEN(MAXLEN)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_cnt(sym_cnt),
    .dec_err(dec_err), .dec_done(dec_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: accumulated bits kept as (value, length) and compared
  // against each symbol's codeword as a bit string.
  int m_hc [1:6];
  int m_len [1:6];
  bit m_loaded, m_done, e_sv, e_err;
  int m_acc, m_alen, m_cnt, m_data;

  logic [19:0] obs;
  assign obs = {sym_valid, dec_err, sym_data, sym_cnt, dec_done, bit_ready};

  function automatic logic [19:0] expv();
    return {e_sv, e_err, 8'(m_data), 8'(m_cnt), m_done, m_loaded && !m_done};
  endfunction

  task automatic model_reset();
    m_loaded = 0; m_done = 0; m_acc = 0; m_alen = 0;
    m_cnt = 0; m_data = 0; e_sv = 0; e_err = 0;
  endtask

  // One clock: drive inputs, advance the model at the edge, settle.
  task automatic cycle(input bit cv, input bit bv, input bit b);
    int hit;
    code_valid = cv; bit_valid = bv; bit_in = b;
    @(posedge clk);
    e_sv = 0; e_err = 0;
    if (cv) begin
      for (int i = 1; i <= 6; i++) begin
        m_hc[i] = int'(t_hc[i]); m_len[i] = t_len[i];
      end
      m_loaded = 1; m_done = 0; m_acc = 0; m_alen = 0; m_cnt = 0;
    end else if (bv && m_loaded && !m_done) begin
      m_acc  = m_acc * 2 + int'(b);
      m_alen = m_alen + 1;
      hit = 0;
      for (int i = 1; i <= 6; i++)
        if (hit == 0 && m_len[i] == m_alen && m_hc[i] == m_acc) hit = i;
      if (hit != 0) begin
        e_sv = 1; m_data = hit; m_acc = 0; m_alen = 0; m_cnt = m_cnt + 1;
        if (m_cnt == TOTAL) m_done = 1;
      end else if (m_alen == MAXLEN) begin
        e_err = 1; m_acc = 0; m_alen = 0;
      end
    end
    #1;
    code_valid = 0; bit_valid = 0;
  endtask

  task automatic set_table1();
    t_hc[1] = 8'd0;  t_len[1] = 1;
    t_hc[2] = 8'd2;  t_len[2] = 2;
    t_hc[3] = 8'd6;  t_len[3] = 3;
    t_hc[4] = 8'd14; t_len[4] = 4;
    t_hc[5] = 8'd30; t_len[5] = 5;
    t_hc[6] = 8'd31; t_len[6] = 5;
  endtask

  task automatic test_reset();
    reset = 1; code_valid = 0; bit_valid = 0; bit_in = 0;
    set_table1();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== expv())
      $display("FAIL reset_state got=%h exp=%h", obs, expv());
    if (obs !== expv()) errors++;
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit bits [6] = '{0, 1, 0, 1, 1, 0};
    int got [$];
    set_table1();
    cycle(1, 0, 0);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL basic_load got=%h exp=%h", obs, expv()); end
    foreach (bits[k]) begin
      cycle(0, 1, bits[k]);
      if (sym_valid) got.push_back(int'(sym_data));
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL basic_bit%0d got=%h exp=%h", k, obs, expv()); end
    end
    checks++;
    if (got.size() != 3 || got[0] != 1 || got[1] != 2 || got[2] != 3 || sym_cnt !== 8'd3) begin
      errors++; $display("FAIL basic_seq got=%p cnt=%0d exp='{1,2,3} cnt=3", got, sym_cnt);
    end
  endtask

  task automatic test_gaps();
    bit bits [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int pulses = 0;
    set_table1();
    cycle(1, 0, 0);
    foreach (bits[k]) begin
      cycle(0, 1, bits[k]);
      if (sym_valid) pulses++;
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL gap_bit%0d got=%h exp=%h", k, obs, expv()); end
      for (int g = 0; g < 3; g++) begin
        cycle(0, 0, 1'($urandom));
        if (sym_valid) pulses++;
        checks++;
        if (obs !== expv()) begin errors++; $display("FAIL gap_idle%0d got=%h exp=%h", k, obs, expv()); end
      end
    end
    checks++;
    if (pulses != 2 || sym_data !== 8'd5 || sym_cnt !== 8'd2) begin
      errors++; $display("FAIL gap_summary pulses=%0d data=%0d cnt=%0d exp 2/5/2", pulses, sym_data, sym_cnt);
    end
  endtask

  task automatic test_error();
    int errs = 0;
    set_table1();
    t_hc[6] = 8'd62; t_len[6] = 6;
    cycle(1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1, k < 7);
      if (dec_err) errs++;
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL err_bit%0d got=%h exp=%h", k, obs, expv()); end
    end
    checks++;
    if (errs != 1 || sym_cnt !== 8'd1 || sym_data !== 8'd1) begin
      errors++; $display("FAIL err_summary errs=%0d cnt=%0d data=%0d exp 1/1/1", errs, sym_cnt, sym_data);
    end
  endtask

  task automatic test_done();
    set_table1();
    cycle(1, 0, 0);
    for (int k = 0; k <= TOTAL; k++) begin
      cycle(0, 1, 0);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL done_bit%0d got=%h exp=%h", k, obs, expv()); end
    end
    checks++;
    if (sym_cnt !== 8'(TOTAL) || dec_done !== 1'b1 || bit_ready !== 1'b0) begin
      errors++; $display("FAIL done_state cnt=%0d done=%b rdy=%b exp %0d/1/0", sym_cnt, dec_done, bit_ready, TOTAL);
    end
    cycle(1, 0, 0);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL done_reload got=%h exp=%h", obs, expv()); end
  endtask

  task automatic test_reset_mid();
    bit bits [3] = '{0, 1, 1};
    set_table1();
    cycle(1, 0, 0);
    foreach (bits[k]) cycle(0, 1, bits[k]);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL rmid_pre got=%h exp=%h", obs, expv()); end
    #3 reset = 1;
    #1;
    model_reset();
    checks++;
    if (obs !== 20'h0) begin errors++; $display("FAIL rmid_async got=%h exp=00000", obs); end
    #2 reset = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      cycle(0, 1, 0);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL rmid_ignored%0d got=%h exp=%h", k, obs, expv()); end
    end
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    checks++;
    if (obs !== expv() || sym_data !== 8'd1) begin
      errors++; $display("FAIL rmid_restart got=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_reload_mid();
    set_table1();
    cycle(1, 0, 0);
    cycle(0, 1, 1);
    cycle(0, 1, 1);
    t_hc[1] = 8'd1; t_len[1] = 1;
    t_hc[2] = 8'd0; t_len[2] = 2;
    t_hc[3] = 8'd2; t_len[3] = 3;
    t_hc[4] = 8'd6; t_len[4] = 4;
    t_hc[5] = 8'd0; t_len[5] = 0;
    t_hc[6] = 8'd7; t_len[6] = 4;
    cycle(1, 1, 0);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL reload_cv got=%h exp=%h", obs, expv()); end
    cycle(0, 1, 1);
    checks++;
    if (obs !== expv() || sym_cnt !== 8'd1 || sym_data !== 8'd1) begin
      errors++; $display("FAIL reload_first got=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int i = 1; i <= 6; i++) begin
        t_len[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 7));
        t_hc[i]  = 8'($urandom) & lmask(t_len[i]);
      end
      cycle(1, 0, 0);
      for (int k = 0; k < 80; k++) begin
        cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, 1'($urandom));
        checks++;
        if (obs !== expv()) begin errors++; $display("FAIL rand_r%0d_c%0d got=%h exp=%h", r, k, obs, expv()); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_error();
    test_done();
    test_reset_mid();
    test_reload_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
